// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Digit counter needs at least one bit even when a single digit covers WIDTH.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the digit-serial adder.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  // Handshake: the adder samples start only while not busy (IDLE or DONE);
  // operands, sub and cin are captured on that edge. busy is high while digits
  // are processed; done is a one-cycle pulse marking s/cout/ovf valid, and
  // those stay stable until the next accepted start.
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );

endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder; chained DIGIT times to form one digit of the serial adder.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain of
// full-adder cells, carry registered between digits, result after WIDTH/DIGIT steps.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  serial_adder_if.slave  bus,
  output state_t         o_state
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_adder: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must divide WIDTH");
  end

  state_t           r_state, w_next;
  logic             w_accept, w_step, w_last;
  logic [WIDTH-1:0] r_op_a, r_op_b, r_s;
  logic             r_carry, r_cout, r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_sum;

  // Digit chain: w_c[DIGIT-1] is the carry into the MSB cell, used for overflow.
  assign w_c[0] = r_carry;
  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    full_adder_cell u_cell (
      .i_a    (r_op_a[g]),
      .i_b    (r_op_b[g]),
      .i_cin  (w_c[g]),
      .o_s    (w_sum[g]),
      .o_cout (w_c[g+1])
    );
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST) begin
          w_last = 1'b1;
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_next   = ST_RUN;
          w_accept = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1, so cin is replaced by a forced carry.
      r_op_a  <= bus.a;
      r_op_b  <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_s     <= '0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_s     <= (r_s >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
      r_op_a  <= r_op_a >> DIGIT;
      r_op_b  <= r_op_b >> DIGIT;
      r_carry <= w_c[DIGIT];
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_cout <= w_c[DIGIT];
        r_ovf  <= w_c[DIGIT-1] ^ w_c[DIGIT];
      end
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.s    = r_s;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign o_state  = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three 8-bit instances (DIGIT 1, 2, 4) exercised with
// directed vectors, ignored restarts, mid-run reset and a random back-to-back stream.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic       tb_sub;
  logic [7:0] tb_a;
  logic [7:0] tb_b;
  logic       tb_cin;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [9:0] res_v [3];
  state_t     st_v  [3];
  int         checks;
  int         errors;
  logic [9:0] exp_q [$];

  serial_adder_if #(.WIDTH(8)) if_d1 ();
  serial_adder_if #(.WIDTH(8)) if_d2 ();
  serial_adder_if #(.WIDTH(8)) if_d4 ();

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d1.slave), .o_state(st_v[0]));
  serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d2.slave), .o_state(st_v[1]));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_d4.slave), .o_state(st_v[2]));

  assign if_d1.start = start_v[0];
  assign if_d2.start = start_v[1];
  assign if_d4.start = start_v[2];
  assign {if_d1.sub, if_d1.a, if_d1.b, if_d1.cin} = {tb_sub, tb_a, tb_b, tb_cin};
  assign {if_d2.sub, if_d2.a, if_d2.b, if_d2.cin} = {tb_sub, tb_a, tb_b, tb_cin};
  assign {if_d4.sub, if_d4.a, if_d4.b, if_d4.cin} = {tb_sub, tb_a, tb_b, tb_cin};
  assign busy_v   = {if_d4.busy, if_d2.busy, if_d1.busy};
  assign done_v   = {if_d4.done, if_d2.done, if_d1.done};
  assign res_v[0] = {if_d1.s, if_d1.cout, if_d1.ovf};
  assign res_v[1] = {if_d2.s, if_d2.cout, if_d2.ovf};
  assign res_v[2] = {if_d4.s, if_d4.cout, if_d4.ovf};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic: {s, cout, ovf} for a +/- b.
  function automatic logic [9:0] ref_model(input logic sub, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
    int          ua, ub, sa, sb, us, ss;
    logic [31:0] u;
    logic        co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      us = ua - ub;
      ss = sa - sb;
      co = (ua >= ub);
    end else begin
      us = ua + ub + int'(cin);
      ss = sa + sb + int'(cin);
      co = (us > 255);
    end
    ov = (ss > 127) || (ss < -128);
    u  = us;
    return {u[7:0], co, ov};
  endfunction

  function automatic int n_of(input int idx);
    case (idx)
      0:       return 8;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  // ---------------- checker / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int idx, input logic sub, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic [9:0] exp, input string tag);
    int cyc;
    @(negedge clk);
    tb_sub = sub; tb_a = a; tb_b = b; tb_cin = cin;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, 32'(busy_v[idx]), 32'd1);
    while (!done_v[idx] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 32'(done_v[idx]), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(n_of(idx) + 1));
    check({tag, "_result"}, 32'(res_v[idx]), 32'(exp));
    check({tag, "_busy_at_done"}, 32'(busy_v[idx]), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_v[idx]), 32'd0);
    check({tag, "_held"}, 32'(res_v[idx]), 32'(exp));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int       dcnt;
    int       t;
    int       last_t;
    int       k;
    logic [9:0] got;
    logic [9:0] e;
    checks  = 0;
    errors  = 0;
    start_v = '0;
    tb_sub  = 1'b0; tb_a = '0; tb_b = '0; tb_cin = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state_%0d", i), 32'(st_v[i]), 32'(ST_IDLE));
      check($sformatf("reset_outs_%0d", i), {19'd0, busy_v[i], done_v[i], res_v[i]}, 32'd0);
    end

    // DIGIT=1 vectors
    run_op(0, 1'b0, 8'h5A, 8'h3C, 1'b0, {8'h96, 1'b0, 1'b1}, "d1_add");
    run_op(0, 1'b1, 8'h10, 8'h20, 1'b1, {8'hF0, 1'b0, 1'b0}, "d1_sub");
    run_op(0, 1'b0, 8'hFF, 8'h01, 1'b1, {8'h01, 1'b1, 1'b0}, "d1_add_cin");
    // DIGIT=4 vector
    run_op(2, 1'b0, 8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1}, "d4_add");

    // Restart request during RUN must be ignored
    @(negedge clk);
    tb_sub = 1'b0; tb_a = 8'hC0; tb_b = 8'h80; tb_cin = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    tb_sub = 1'b1; tb_a = 8'h01; tb_b = 8'h02; tb_cin = 1'b0;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    dcnt = 0;
    got  = '0;
    for (int i = 0; i < 12; i++) begin
      if (done_v[1]) begin
        dcnt++;
        got = res_v[1];
      end
      @(negedge clk);
    end
    check("ignore_done_count", 32'(dcnt), 32'd1);
    check("ignore_result", 32'(got), 32'({8'h41, 1'b1, 1'b1}));

    // Reset for one edge in the middle of RUN
    @(negedge clk);
    tb_sub = 1'b0; tb_a = 8'hFF; tb_b = 8'hFF; tb_cin = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_state", 32'(st_v[1]), 32'(ST_IDLE));
    check("rst_outs", {20'd0, busy_v[1], done_v[1], res_v[1]}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_v[1]) dcnt++;
    end
    check("rst_no_done", 32'(dcnt), 32'd0);
    run_op(1, 1'b1, 8'h80, 8'h01, 1'b0, {8'h7F, 1'b1, 1'b1}, "d2_after_rst");

    // Random stream, start held high, inputs scrambled while running
    @(negedge clk);
    tb_sub = 1'($urandom_range(1)); tb_a = 8'($urandom); tb_b = 8'($urandom);
    tb_cin = 1'($urandom_range(1));
    exp_q.push_back(ref_model(tb_sub, tb_a, tb_b, tb_cin));
    start_v[1] = 1'b1;
    t = 0;
    last_t = 0;
    for (int i = 0; i < 1000; i++) begin
      k = 0;
      do begin
        @(negedge clk);
        t++;
        k++;
        if (!done_v[1]) begin
          tb_sub = 1'($urandom_range(1)); tb_a = 8'($urandom); tb_b = 8'($urandom);
          tb_cin = 1'($urandom_range(1));
        end
      end while (!done_v[1] && k < 20);
      check($sformatf("rand_done_%0d", i), 32'(done_v[1]), 32'd1);
      if (!done_v[1]) break;
      e = exp_q.pop_front();
      check($sformatf("rand_result_%0d", i), 32'(res_v[1]), 32'(e));
      if (i > 0) check($sformatf("rand_period_%0d", i), 32'(t - last_t), 32'd5);
      last_t = t;
      if (i < 999) begin
        tb_sub = 1'($urandom_range(1)); tb_a = 8'($urandom); tb_b = 8'($urandom);
        tb_cin = 1'($urandom_range(1));
        exp_q.push_back(ref_model(tb_sub, tb_a, tb_b, tb_cin));
      end else begin
        start_v[1] = 1'b0;
      end
    end
    @(negedge clk);
    check("rand_final_idle", 32'(st_v[1]), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
